// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The master side is fetch plus decode; the slave side is the queue itself.
interface if_id_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {pc, instr} pairs between fetch and decode.
// The head is presented combinationally from storage; flush discards everything.
module if_id_queue #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input logic           clk,
    input logic           reset,
    if_id_queue_if.slave  q
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic in_ready_c;
    logic out_valid_c;
    logic push_c;
    logic pop_c;

    // Full blocks a push even when a pop happens on the same edge.
    always_comb begin
        in_ready_c  = (cnt < CW'(DEPTH));
        out_valid_c = (cnt != '0);
        push_c      = q.in_valid  && in_ready_c;
        pop_c       = q.out_ready && out_valid_c;
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_c) wr_ptr <= AW'(wr_ptr + 1'b1);
            if (pop_c)  rd_ptr <= AW'(rd_ptr + 1'b1);
            case ({push_c, pop_c})
                2'b10:   cnt <= CW'(cnt + 1'b1);
                2'b01:   cnt <= CW'(cnt - 1'b1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is never reset; outputs ignore it while empty.
    always_ff @(posedge clk) begin
        if (push_c && !q.flush) begin
            mem_pc[wr_ptr]    <= q.in_pc;
            mem_instr[wr_ptr] <= q.in_instr;
        end
    end

    always_comb begin
        q.in_ready  = in_ready_c;
        q.out_valid = out_valid_c;
        q.count     = cnt;
        q.out_pc    = 32'h0;
        q.out_instr = NOP;
        if (out_valid_c) begin
            q.out_pc    = mem_pc[rd_ptr];
            q.out_instr = mem_instr[rd_ptr];
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios followed by random traffic.
module tb_if_id_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    // Expected queue contents, oldest first: {pc, instr}.
    logic [63:0] sb[$];

    if_id_queue_if #(.DEPTH(DEPTH)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle, compare outputs with the model and retire a pop.
    initial begin
        logic [63:0] head;
        forever begin
            @(negedge clk);
            chk("count",     32'(bus.count),     32'(sb.size()));
            chk("in_ready",  32'(bus.in_ready),  32'(sb.size() < DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                head = sb[0];
                chk("out_pc",    bus.out_pc,    head[63:32]);
                chk("out_instr", bus.out_instr, head[31:0]);
                if (bus.out_ready) void'(sb.pop_front());
            end else begin
                chk("empty_pc",    bus.out_pc,    32'h0);
                chk("empty_instr", bus.out_instr, NOP);
            end
        end
    end

    // One clock of stimulus; the model takes the push on the edge if there was room.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
        logic acc;
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.flush     = fl;
        acc = v && !reset && (sb.size() < DEPTH);
        @(posedge clk);
        if (reset || fl) sb.delete();
        else if (acc)    sb.push_back({pc, ins});
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse between edges, checked before the next edge.
    task automatic async_reset();
        #1 reset = 1'b1;
        sb.delete();
        #1;
        chk("async_rst_count", 32'(bus.count),     32'h0);
        chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("async_rst_instr", bus.out_instr,      NOP);
        chk("async_rst_ready", 32'(bus.in_ready),  32'h1);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle();

        // First push becomes visible one cycle later.
        cyc(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #1;
        chk("first_push_pc",    bus.out_pc,        32'h0);
        chk("first_push_instr", bus.out_instr,     32'h0050_0093);
        chk("first_push_count", 32'(bus.count),    32'h1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Fill to full, fifth push held, then drain in order.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'h10, 32'h1004, 1'b0, 1'b0);
        chk("full_count", 32'(bus.count),    32'h4);
        chk("full_ready", 32'(bus.in_ready), 32'h0);
        // Pop while full: the simultaneous push must still be refused.
        cyc(1'b1, 32'h14, 32'h1005, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Steady push+pop at count 2 across pointer wrap.
        cyc(1'b1, 32'h200, 32'h2000, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 32'h2001, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'h208 + 32'(i * 4), 32'h2002 + 32'(i), 1'b1, 1'b0);
        chk("steady_count", 32'(bus.count), 32'h2);
        for (int i = 0; i < 2; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with a same-cycle push and pop at count 3.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(i * 4), 32'h3000 + 32'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'h30C, 32'h3003, 1'b1, 1'b1);
        chk("flush_count", 32'(bus.count),     32'h0);
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        chk("flush_instr", bus.out_instr,      NOP);
        cyc(1'b1, 32'h400, 32'h4000, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset with two entries queued, then a fresh push.
        cyc(1'b1, 32'h500, 32'h5000, 1'b0, 1'b0);
        cyc(1'b1, 32'h504, 32'h5001, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        async_reset();
        cyc(1'b1, 32'h100, 32'h0010_0113, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #1;
        chk("post_reset_pc", bus.out_pc, 32'h100);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic with phase-varying bias towards full or empty.
        pc = 32'h8000;
        for (int n = 0; n < 3000; n++) begin
            int unsigned bias;
            bias = 32'((n / 250) % 3);
            if ($urandom_range(0, 299) == 0) begin
                bus.in_valid = 1'b0;
                async_reset();
            end else begin
                cyc(($urandom_range(0, 3) < 1 + bias),
                    pc, $urandom(),
                    ($urandom_range(0, 3) >= bias),
                    ($urandom_range(0, 39) == 0));
                pc = pc + 32'h4;
            end
        end

        idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-002 SHALL have parameter NOP, default 32'h0000_0013, instruction presented when empty.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, fetch presents an instruction.
REQ-006 SHALL have port in_pc, input, 32, address of the presented instruction.
REQ-007 SHALL have port in_instr, input, 32, instruction word from instruction memory.
REQ-008 SHALL have port in_ready, output, 1, queue accepts a push this cycle.
REQ-009 SHALL have port out_valid, output, 1, head entry available to decode.
REQ-010 SHALL have port out_pc, output, 32, head entry PC.
REQ-011 SHALL have port out_instr, output, 32, head entry instruction.
REQ-012 SHALL have port out_ready, input, 1, decode consumes the head this cycle (low = hazard stall).
REQ-013 SHALL have port flush, input, 1, discard all entries (taken branch/jump).
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-015 SHALL store {pc, instr} pairs in a circular buffer with write pointer, read pointer and occupancy counter.
REQ-016 Push SHALL occur when in_valid and in_ready are both high at a rising edge; entry is written at the write pointer, which then advances.
REQ-017 Pop SHALL occur when out_valid and out_ready are both high at a rising edge; the read pointer then advances.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0 without gaps.
REQ-019 in_ready SHALL equal (count < DEPTH); no same-cycle pass-through when full, even if a pop occurs.
REQ-020 out_valid SHALL equal (count != 0); out_pc/out_instr SHALL be the entry at the read pointer, combinationally, with zero added latency from storage.
REQ-021 When empty, out_pc SHALL be 0 and out_instr SHALL be NOP.
REQ-022 Push-to-visible latency SHALL be one cycle: an entry pushed at edge N is at the head (if queue was empty) after edge N.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-024 Simultaneous push and pop when empty SHALL be impossible (out_valid low); push alone proceeds.
REQ-025 Head entry SHALL remain stable while out_valid is high and out_ready low.
REQ-026 flush SHALL take priority: at the edge, count and both pointers go to 0 and any same-cycle push or pop is discarded; out_valid low next cycle.
REQ-027 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-028 reset high SHALL immediately clear pointers and count to 0; in_ready=1, out_valid=0, out_pc=0, out_instr=NOP, count=0.
REQ-029 Storage contents need not be cleared; outputs SHALL not depend on them while empty.
REQ-030 reset asserted mid-operation SHALL drop all entries; first push after deassertion SHALL behave as from an empty queue.

Verification
REQ-031 Reset, then push pc=0x0 instr=0x00500093 with out_ready=0 -> next cycle out_valid=1, out_pc=0x0, out_instr=0x00500093, count=1.
REQ-032 DEPTH=4, out_ready=0, push pc 0x0,0x4,0x8,0xC -> count=4, in_ready=0; fifth push held; pops return 0x0,0x4,0x8,0xC in order.
REQ-033 count=2, in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, pointers wrap, PC order preserved.
REQ-034 count=3 with push and pop in the same cycle as flush=1 -> next cycle count=0, out_valid=0, out_instr=0x00000013, pushed entry absent.
REQ-035 count=2, assert reset asynchronously between edges -> count=0 and out_valid=0 before next edge; after release push pc=0x100 -> head pc=0x100.
